// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 transmit path and its two-port arbiter.
package uart_pkg;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;
  typedef enum logic       {ARB_FREE, ARB_HELD} arb_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: one byte per load, registered line output, ready in the last stop-bit cycle
// so a following byte can start with no idle gap.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CPB = 217
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int            CW       = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [2:0]    IDX_LAST = 3'(FRAME_BITS - 3);

  ser_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  assign ready = (state == SER_IDLE) || ((state == SER_STOP) && (cnt == CNT_LAST));
  assign busy  = (state != SER_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= SER_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= STOP_BIT;
    end else begin
      case (state)
        SER_IDLE: begin
          if (load) begin
            state <= SER_START;
            cnt   <= '0;
            shreg <= data;
            tx    <= START_BIT;
          end
        end
        SER_START: begin
          if (cnt == CNT_LAST) begin
            state <= SER_DATA;
            cnt   <= '0;
            idx   <= '0;
            tx    <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SER_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= SER_STOP;
              tx    <= STOP_BIT;
            end else begin
              // shreg[0] is on the line; shift so the next bit lands there
              idx   <= idx + 1'b1;
              shreg <= {1'b0, shreg[7:1]};
              tx    <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SER_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (load) begin
              state <= SER_START;
              shreg <= data;
              tx    <= START_BIT;
            end else begin
              state <= SER_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter for one UART TX line: round-robin grant, ownership held per message
// until EOM_BYTE is sent or the owner goes idle for MAX_IDLE cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 25_000_000,
  parameter int         BAUD        = 115_200,
  parameter logic [7:0] EOM_BYTE    = 8'h0A,
  parameter int         MAX_IDLE    = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_line,
  output logic [1:0] owner,
  output logic       busy
);

  localparam int            CPB       = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int            IW        = $clog2(MAX_IDLE + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(MAX_IDLE - 1);

  arb_state_t    arb_state;
  logic          last_winner;
  logic [IW-1:0] idle_cnt;
  logic          ser_ready;
  logic          win;
  logic          acc0, acc1, accept, acc_eom, owner_valid;
  logic [7:0]    acc_data;

  // both valid: the one after last_winner; otherwise the lone valid one
  always_comb begin
    win = req1_valid;
    if (req0_valid && req1_valid) win = ~last_winner;
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (arb_state == ARB_FREE) begin
      if (req0_valid || req1_valid) begin
        req0_ready = ser_ready & ~win;
        req1_ready = ser_ready &  win;
      end
    end else begin
      req0_ready = ser_ready & owner[0];
      req1_ready = ser_ready & owner[1];
    end
  end

  assign acc0        = req0_valid & req0_ready;
  assign acc1        = req1_valid & req1_ready;
  assign accept      = acc0 | acc1;
  assign acc_data    = acc1 ? req1_data : req0_data;
  assign acc_eom     = accept && (acc_data == EOM_BYTE);
  assign owner_valid = (owner[0] & req0_valid) | (owner[1] & req1_valid);

  always_ff @(posedge CLK) begin
    if (RST) begin
      arb_state   <= ARB_FREE;
      owner       <= 2'b00;
      last_winner <= 1'b1;
      idle_cnt    <= '0;
    end else begin
      case (arb_state)
        ARB_FREE: begin
          idle_cnt <= '0;
          if (accept) begin
            last_winner <= acc1;
            // a lone EOM is a complete message: send it without taking ownership
            if (!acc_eom) begin
              arb_state <= ARB_HELD;
              owner     <= acc1 ? 2'b10 : 2'b01;
            end
          end
        end
        ARB_HELD: begin
          if (acc_eom) begin
            arb_state <= ARB_FREE;
            owner     <= 2'b00;
            idle_cnt  <= '0;
          end else if (!owner_valid && ser_ready) begin
            if (idle_cnt == IDLE_LAST) begin
              arb_state <= ARB_FREE;
              owner     <= 2'b00;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        default: begin
          arb_state <= ARB_FREE;
          owner     <= 2'b00;
        end
      endcase
    end
  end

  uart_tx_serializer #(.CPB(CPB)) u_ser (
    .CLK   (CLK),
    .RST   (RST),
    .load  (accept),
    .data  (acc_data),
    .ready (ser_ready),
    .busy  (busy),
    .tx    (tx_line)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-level frame/ownership model checked every cycle, plus
// hand-computed checks on accept timing, frame bits and ownership per scenario.
module tb_uart_tx_arbiter;

  localparam int CPB  = 4;
  localparam int MAXI = 16;
  localparam int FR   = 10 * CPB;
  localparam int HN   = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, tx_line, busy;
  logic [1:0] owner;

  uart_tx_arbiter #(
    .CLK_FREQ_HZ (4),
    .BAUD        (1),
    .EOM_BYTE    (8'h0A),
    .MAX_IDLE    (MAXI)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_line    (tx_line),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] q0[$], q1[$];
  logic       acc0_seen = 1'b0, acc1_seen = 1'b0;
  int         acc_cyc[$], acc_port[$];
  logic [7:0] acc_byte[$];
  logic       tx_hist[0:HN-1];
  logic       busy_hist[0:HN-1];
  logic [1:0] own_hist[0:HN-1];

  // model state: frame start cycle/byte, owner (0 none, 1 req0, 2 req1), last winner, idle run
  int         m_ft = -1, m_own = 0, m_lw = 1, m_idle = 0, m_d, m_k, m_win;
  logic [7:0] m_fb = 8'h00, m_ab;
  logic       m_sr, m_acc0, m_acc1, e_tx, e_busy, e_r0, e_r1;
  logic [1:0] e_own;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] get_frame(input int t);
    logic [9:0] f;
    for (int k = 0; k < 10; k++) f[k] = tx_hist[t + 1 + k*CPB + CPB/2];
    return f;
  endfunction

  always @(negedge clk) begin
    if (cyc < HN) begin
      tx_hist[cyc]   = tx_line;
      busy_hist[cyc] = busy;
      own_hist[cyc]  = owner;
    end
    acc0_seen = req0_valid && req0_ready && !rst;
    acc1_seen = req1_valid && req1_ready && !rst;
    if (acc0_seen || acc1_seen) begin
      acc_cyc.push_back(cyc);
      acc_port.push_back(acc1_seen ? 1 : 0);
      acc_byte.push_back(acc1_seen ? req1_data : req0_data);
    end
    if (rst) begin
      m_ft = -1; m_own = 0; m_lw = 1; m_idle = 0;
    end else begin
      m_d  = cyc - m_ft;
      m_sr = (m_ft < 0) || (m_d >= FR);
      e_tx = 1'b1; e_busy = 1'b0;
      if (m_ft >= 0 && m_d >= 1 && m_d <= FR) begin
        e_busy = 1'b1;
        m_k = (m_d - 1) / CPB;
        if (m_k == 0) e_tx = 1'b0;
        else if (m_k <= 8) e_tx = m_fb[m_k-1];
      end
      e_r0 = 1'b0; e_r1 = 1'b0;
      if (m_own == 0) begin
        if (req0_valid || req1_valid) begin
          m_win = (req0_valid && req1_valid) ? 1 - m_lw : (req1_valid ? 1 : 0);
          e_r0 = m_sr && (m_win == 0);
          e_r1 = m_sr && (m_win == 1);
        end
      end else begin
        e_r0 = m_sr && (m_own == 1);
        e_r1 = m_sr && (m_own == 2);
      end
      e_own = (m_own == 0) ? 2'b00 : (m_own == 1) ? 2'b01 : 2'b10;
      chk("tx_line", tx_line, e_tx);
      chk("busy", busy, e_busy);
      chk("owner", owner, e_own);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);

      m_acc0 = req0_valid && e_r0;
      m_acc1 = req1_valid && e_r1;
      m_ab   = m_acc1 ? req1_data : req0_data;
      if (m_acc0 || m_acc1) begin m_ft = cyc; m_fb = m_ab; end
      if (m_own == 0) begin
        m_idle = 0;
        if (m_acc0 || m_acc1) begin
          m_lw = m_acc1 ? 1 : 0;
          if (m_ab != 8'h0A) m_own = m_acc1 ? 2 : 1;
        end
      end else if ((m_acc0 || m_acc1) && m_ab == 8'h0A) begin
        m_own = 0; m_idle = 0;
      end else if (!((m_own == 1 && req0_valid) || (m_own == 2 && req1_valid)) && m_sr) begin
        m_idle++;
        if (m_idle == MAXI) begin m_own = 0; m_idle = 0; end
      end else begin
        m_idle = 0;
      end
    end
    cyc++;
  end

  // byte-stream sources: present queue heads, pop on observed handshake
  always @(posedge clk) begin
    #1;
    if (acc0_seen && q0.size() > 0) void'(q0.pop_front());
    if (acc1_seen && q1.size() > 0) void'(q1.pop_front());
    acc0_seen = 1'b0;
    acc1_seen = 1'b0;
    req0_valid = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    q0.delete(); q1.delete();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy || req0_valid || req1_valid) && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, (n < 2000), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  int n, t, L, cnt;
  logic [7:0] exp_b[6];
  int         exp_p[6];

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("reset_tx", tx_line, 1);
    chk("reset_owner", owner, 2'b00);
    chk("reset_busy", busy, 0);

    // 1: single byte from req0
    do_reset();
    L = cyc; n = acc_cyc.size();
    q0.push_back(8'h41);
    wait_done("t1_done");
    chk("t1_acc_count", acc_cyc.size() - n, 1);
    t = acc_cyc[n];
    chk("t1_latency", t - L, 1);
    chk("t1_frame", get_frame(t), 10'b1010000010);
    cnt = 0;
    for (int i = t + 1; i <= t + 41; i++) cnt += busy_hist[i];
    chk("t1_busy_cycles", cnt, 40);
    chk("t1_owner", own_hist[t+1], 2'b01);

    // 2: both messages pending from reset
    do_reset();
    n = acc_cyc.size();
    q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h0A);
    q1.push_back(8'h78); q1.push_back(8'h79); q1.push_back(8'h0A);
    exp_b = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};
    exp_p = '{0, 0, 0, 1, 1, 1};
    wait_done("t2_done");
    chk("t2_acc_count", acc_cyc.size() - n, 6);
    if (acc_cyc.size() - n == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t2_port", acc_port[n+i], exp_p[i]);
        chk("t2_byte", acc_byte[n+i], exp_b[i]);
        chk("t2_frame", get_frame(acc_cyc[n+i]), {1'b1, exp_b[i], 1'b0});
        if (i > 0) chk("t2_gap", acc_cyc[n+i] - acc_cyc[n+i-1], 40);
      end
    end

    // 3: owner goes quiet after one byte, other requester waits for timeout
    do_reset();
    n = acc_cyc.size();
    q0.push_back(8'h41); q1.push_back(8'h5A);
    wait_done("t3_done");
    chk("t3_acc_count", acc_cyc.size() - n, 2);
    if (acc_cyc.size() - n == 2) begin
      t = acc_cyc[n];
      chk("t3_first_port", acc_port[n], 0);
      chk("t3_second_port", acc_port[n+1], 1);
      chk("t3_release_delay", acc_cyc[n+1] - t, 56);
      chk("t3_owner_held", own_hist[t+55], 2'b01);
      chk("t3_owner_free", own_hist[t+56], 2'b00);
    end

    // 4: back-to-back bytes from req1
    do_reset();
    n = acc_cyc.size();
    q1.push_back(8'h55); q1.push_back(8'hAA);
    wait_done("t4_done");
    chk("t4_acc_count", acc_cyc.size() - n, 2);
    if (acc_cyc.size() - n == 2) begin
      t = acc_cyc[n];
      chk("t4_gap", acc_cyc[n+1] - t, 40);
      chk("t4_frame0", get_frame(t), 10'b1010101010);
      chk("t4_frame1", get_frame(t + 40), 10'b1101010100);
      chk("t4_stop_end", tx_hist[t+40], 1);
      chk("t4_next_start", tx_hist[t+41], 0);
    end

    // 5: reset in the middle of a frame
    do_reset();
    n = acc_cyc.size();
    q0.push_back(8'h58);
    cnt = 0;
    while (acc_cyc.size() == n && cnt < 20) begin @(posedge clk); #2; cnt++; end
    chk("t5_accept_seen", (cnt < 20), 1);
    t = (acc_cyc.size() > n) ? acc_cyc[n] : cyc;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    q0.delete(); q1.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("t5_tx_before", tx_hist[t+10], 0);
    chk("t5_owner_before", own_hist[t+10], 2'b01);
    chk("t5_tx_after", tx_hist[t+11], 1);
    chk("t5_busy_after", busy_hist[t+11], 0);
    chk("t5_owner_after", own_hist[t+11], 2'b00);
    n = acc_cyc.size();
    q1.push_back(8'h66);
    wait_done("t5_done");
    chk("t5_acc_count", acc_cyc.size() - n, 1);
    if (acc_cyc.size() - n == 1) begin
      chk("t5_port", acc_port[n], 1);
      chk("t5_frame", get_frame(acc_cyc[n]), 10'b1011001100);
    end

    // 6: lone EOM in FREE, then round-robin resumes at req0
    do_reset();
    n = acc_cyc.size();
    q1.push_back(8'h0A);
    wait_done("t6_done");
    chk("t6_acc_count", acc_cyc.size() - n, 1);
    if (acc_cyc.size() - n == 1) begin
      t = acc_cyc[n];
      chk("t6_port", acc_port[n], 1);
      chk("t6_frame", get_frame(t), 10'b1000010100);
      chk("t6_owner_free", own_hist[t+1], 2'b00);
      chk("t6_owner_free_late", own_hist[t+20], 2'b00);
    end
    n = acc_cyc.size();
    q0.push_back(8'h33); q1.push_back(8'h44);
    wait_done("t6b_done");
    chk("t6b_acc_count", acc_cyc.size() - n, 2);
    if (acc_cyc.size() - n == 2) begin
      chk("t6b_first_port", acc_port[n], 0);
      chk("t6b_first_byte", acc_byte[n], 8'h33);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
    $fatal(1);
  end

endmodule
